// File: rtl/mix_columns_engine.sv
// Sequential AES MixColumns / InvMixColumns over a full 128-bit state.
// The state is transformed in place, COLS_PER_CYCLE columns per clock, behind valid/ready handshakes.
module mix_columns_engine #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_inverse,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int NUM_BEATS = 4 / COLS_PER_CYCLE;
    localparam logic [1:0] LAST_BEAT = 2'(NUM_BEATS - 1);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("mix_columns_engine: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [1:0]   cnt;
    logic [1:0]   cnt_next;
    logic [127:0] work;
    logic [127:0] work_next;
    logic         inverse_q;
    logic         inverse_next;
    logic         accept;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Byte 0 of a column sits in bits [31:24]; every multiple is built from the x2/x4/x8 chain.
    function automatic logic [31:0] mix_column(input logic [31:0] col, input logic inverse);
        logic [7:0]  a  [4];
        logic [7:0]  x2 [4];
        logic [7:0]  x4 [4];
        logic [7:0]  x8 [4];
        logic [7:0]  m3 [4];
        logic [7:0]  m9 [4];
        logic [7:0]  mb [4];
        logic [7:0]  md [4];
        logic [7:0]  me [4];
        logic [31:0] res;
        int          r1;
        int          r2;
        int          r3;
        for (int k = 0; k < 4; k++) begin
            a[k]  = col[31-8*k -: 8];
            x2[k] = xtime(a[k]);
            x4[k] = xtime(x2[k]);
            x8[k] = xtime(x4[k]);
            m3[k] = x2[k] ^ a[k];
            m9[k] = x8[k] ^ a[k];
            mb[k] = x8[k] ^ x2[k] ^ a[k];
            md[k] = x8[k] ^ x4[k] ^ a[k];
            me[k] = x8[k] ^ x4[k] ^ x2[k];
        end
        res = '0;
        for (int r = 0; r < 4; r++) begin
            r1 = (r + 1) % 4;
            r2 = (r + 2) % 4;
            r3 = (r + 3) % 4;
            if (inverse) begin
                res[31-8*r -: 8] = me[r] ^ mb[r1] ^ md[r2] ^ m9[r3];
            end else begin
                res[31-8*r -: 8] = x2[r] ^ m3[r1] ^ a[r2] ^ a[r3];
            end
        end
        return res;
    endfunction

    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        work_next    = work;
        inverse_next = inverse_q;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        accept       = 1'b0;

        case (state)
            IDLE: begin
                in_ready = 1'b1;
            end
            RUN: begin
                busy = 1'b1;
                for (int j = 0; j < COLS_PER_CYCLE; j++) begin
                    work_next[127 - 32*((int'(cnt) % NUM_BEATS)*COLS_PER_CYCLE + j) -: 32] =
                        mix_column(work[127 - 32*((int'(cnt) % NUM_BEATS)*COLS_PER_CYCLE + j) -: 32],
                                   inverse_q);
                end
                cnt_next = cnt + 2'd1;
                if (cnt == LAST_BEAT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // A handoff in DONE may coincide with a new accept, which goes straight to RUN.
        accept = in_valid & in_ready;
        if (accept) begin
            work_next    = in_state;
            inverse_next = in_inverse;
            cnt_next     = 2'd0;
            state_next   = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 2'd0;
            work      <= '0;
            inverse_q <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            work      <= work_next;
            inverse_q <= inverse_next;
        end
    end

    assign out_state = (state == DONE) ? work : '0;

endmodule
